// File: rtl/duty_meas_ctrl_pkg.sv
// Shared types and helpers for the duty/phase measurement sequencer.
// Holds FSM encodings, result error bit positions and the count sanity check.
package duty_meas_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int ERR_STALE    = 0;
    localparam int ERR_SUM      = 1;
    localparam int MIN_GATE_DEF = 16;

    // Sum and difference carried at 33 bits so high+low can never wrap.
    function automatic logic [1:0] eval_err(input logic [31:0] r,
                                            input logic [31:0] h,
                                            input logic [31:0] l,
                                            input logic [31:0] pre,
                                            input logic [31:0] tol);
        logic [32:0] sum;
        logic [32:0] diff;
        logic [1:0]  err;
        sum  = {1'b0, h} + {1'b0, l};
        diff = ({1'b0, r} >= sum) ? ({1'b0, r} - sum) : (sum - {1'b0, r});
        err  = '0;
        err[ERR_STALE] = (r == pre);
        err[ERR_SUM]   = (diff > {1'b0, tol});
        return err;
    endfunction

endpackage

// File: rtl/duty_meas_ctrl_gate_timer.sv
// Loadable down-counter with zero flag; parks at zero until reloaded.
// Used for both the gate window and the post-gate settle window.
module gate_timer #(
    parameter int W = 32
) (
    input  logic         clk100M,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && !zero)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/duty_meas_ctrl.sv
// Measurement sequencer for the 400M duty/phase counter: drives its gate,
// waits for results to settle, snapshots and sanity-checks them, hands off to host.
module duty_meas_ctrl
    import duty_meas_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4096,
    parameter int unsigned TOL        = 2,
    parameter int unsigned MIN_GATE   = MIN_GATE_DEF
) (
    input  logic        clk100M,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] gate_len,
    output logic        gate,
    output logic        busy,
    input  logic [31:0] cnt_r_in,
    input  logic [31:0] cnt_h_in,
    input  logic [31:0] cnt_l_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_total,
    output logic [31:0] res_high,
    output logic [31:0] res_low,
    output logic [1:0]  res_err
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t        state, state_d;
    logic          gate_d, vld_d;
    logic          gate_ld, settle_ld, cap;
    logic [31:0]   len_eff, pre_r;
    logic [31:0]   g_cnt;
    logic [SW-1:0] s_cnt;
    logic          g_zero, s_zero;

    assign len_eff = (gate_len < MIN_GATE) ? 32'(MIN_GATE) : gate_len;
    assign busy    = (state != ST_IDLE);

    // Loaded with len-1 so the window spans len-1..0, i.e. exactly len cycles.
    gate_timer #(.W(32)) u_gate_tmr (
        .clk100M  (clk100M),
        .rst_n    (rst_n),
        .load     (gate_ld),
        .load_val (len_eff - 32'd1),
        .en       (state == ST_GATE),
        .cnt      (g_cnt),
        .zero     (g_zero)
    );

    gate_timer #(.W(SW)) u_settle_tmr (
        .clk100M  (clk100M),
        .rst_n    (rst_n),
        .load     (settle_ld),
        .load_val (SW'(SETTLE_CYC - 1)),
        .en       (state == ST_SETTLE),
        .cnt      (s_cnt),
        .zero     (s_zero)
    );

    always_comb begin
        state_d   = state;
        gate_d    = gate;
        vld_d     = res_valid;
        gate_ld   = 1'b0;
        settle_ld = 1'b0;
        cap       = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            gate_d  = 1'b0;
            vld_d   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    gate_ld = 1'b1;
                    gate_d  = 1'b1;
                    state_d = ST_GATE;
                end
                ST_GATE: if (g_zero) begin
                    gate_d    = 1'b0;
                    settle_ld = 1'b1;
                    state_d   = ST_SETTLE;
                end
                ST_SETTLE: if (s_zero) state_d = ST_CHECK;
                ST_CHECK: begin
                    cap     = 1'b1;
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end
                ST_HOLD: if (res_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    gate_d  = 1'b0;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gate      <= 1'b0;
            res_valid <= 1'b0;
            pre_r     <= '0;
            res_total <= '0;
            res_high  <= '0;
            res_low   <= '0;
            res_err   <= '0;
        end else begin
            state     <= state_d;
            gate      <= gate_d;
            res_valid <= vld_d;
            if (gate_ld)
                pre_r <= cnt_r_in;
            if (cap) begin
                res_total <= cnt_r_in;
                res_high  <= cnt_h_in;
                res_low   <= cnt_l_in;
                res_err   <= eval_err(cnt_r_in, cnt_h_in, cnt_l_in, pre_r, 32'(TOL));
            end
        end
    end

endmodule

// File: tb/tb_duty_meas_ctrl.sv
// Bench for duty_meas_ctrl: scoreboarded measurements, gate timing, error flags,
// abort and async reset behaviour.
module tb_duty_meas_ctrl;

    localparam int S   = 64;
    localparam int TOL = 2;

    typedef struct {
        logic [31:0] t;
        logic [31:0] h;
        logic [31:0] l;
        logic [1:0]  e;
    } exp_t;

    logic        clk100M = 1'b0;
    logic        rst_n;
    logic        start, abort, res_ready;
    logic [31:0] gate_len, cnt_r_in, cnt_h_in, cnt_l_in;
    logic        gate, busy, res_valid;
    logic [31:0] res_total, res_high, res_low;
    logic [1:0]  res_err;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    duty_meas_ctrl #(.SETTLE_CYC(S), .TOL(TOL), .MIN_GATE(16)) dut (
        .clk100M   (clk100M),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .gate_len  (gate_len),
        .gate      (gate),
        .busy      (busy),
        .cnt_r_in  (cnt_r_in),
        .cnt_h_in  (cnt_h_in),
        .cnt_l_in  (cnt_l_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_total (res_total),
        .res_high  (res_high),
        .res_low   (res_low),
        .res_err   (res_err)
    );

    always #5 clk100M = ~clk100M;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100M);
        #1;
    endtask

    function automatic logic [1:0] model_err(input logic [31:0] pre, input logic [31:0] r,
                                             input logic [31:0] h, input logic [31:0] l);
        longint d;
        logic [1:0] e;
        d = longint'({32'h0, r}) - (longint'({32'h0, h}) + longint'({32'h0, l}));
        if (d < 0) d = -d;
        e[1] = (d > TOL);
        e[0] = (r == pre);
        return e;
    endfunction

    // Start a measurement, check gate width and result latency, queue the expectation.
    task automatic run_meas(input logic [31:0] len, input int exp_w, input logic [31:0] pre,
                            input logic [31:0] r, input logic [31:0] h, input logic [31:0] l,
                            input bit poke_start);
        int w, n;
        exp_t e;
        cnt_r_in = pre; cnt_h_in = 32'd0; cnt_l_in = 32'd0;
        gate_len = len; start = 1'b1;
        tick();
        start = 1'b0; gate_len = 32'd7;
        check("gate_rise", gate, 1);
        check("busy_rise", busy, 1);
        w = 1;
        for (int i = 0; i < 2000; i++) begin
            if (poke_start && i == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (!gate) break;
            w++;
        end
        check("gate_width", w, exp_w);
        cnt_r_in = r; cnt_h_in = h; cnt_l_in = l;
        e = '{r, h, l, model_err(pre, r, h, l)};
        sb.push_back(e);
        n = 0;
        while (!res_valid && n < S + 50) begin
            tick();
            n++;
        end
        check("result_latency", n, S + 1);
    endtask

    task automatic finish_meas(input int hold_cyc);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("res_total", res_total, e.t);
        check("res_high", res_high, e.h);
        check("res_low", res_low, e.l);
        check("res_err", res_err, e.e);
        if (hold_cyc > 0) begin
            for (int i = 0; i < hold_cyc; i++) begin
                start = (i % 17 == 3);
                cnt_r_in = $urandom; cnt_h_in = $urandom; cnt_l_in = $urandom;
                tick();
            end
            start = 1'b0;
            check("hold_valid", res_valid, 1);
            check("hold_busy", busy, 1);
            check("hold_total", res_total, e.t);
            check("hold_high", res_high, e.h);
            check("hold_low", res_low, e.l);
            check("hold_err", res_err, e.e);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hs_valid_fall", res_valid, 0);
        check("hs_busy_fall", busy, 0);
        check("hs_gate", gate, 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        gate_len = '0; cnt_r_in = '0; cnt_h_in = '0; cnt_l_in = '0;
        #12;
        check("rst_gate", gate, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_total", res_total, 0);
        check("rst_err", res_err, 0);
        tick(); rst_n = 1'b1; tick();

        // res_ready while idle must do nothing
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("idle_ready_busy", busy, 0);

        run_meas(32'd1000, 1000, 32'd0, 32'd1000, 32'd250, 32'd750, 0);
        finish_meas(0);
        run_meas(32'd16, 16, 32'd0, 32'd1000, 32'd250, 32'd740, 0);
        finish_meas(0);
        run_meas(32'd20, 20, 32'd5, 32'd1000, 32'd250, 32'd748, 0);
        finish_meas(0);
        run_meas(32'd20, 20, 32'd5, 32'd1000, 32'd250, 32'd747, 0);
        finish_meas(0);
        run_meas(32'd20, 20, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd2, 0);
        finish_meas(0);
        run_meas(32'd30, 30, 32'd500, 32'd500, 32'd200, 32'd300, 0);
        finish_meas(0);

        // abort 50 cycles into the gate
        gate_len = 32'd1000; start = 1'b1; tick(); start = 1'b0;
        repeat (49) tick();
        check("pre_abort_gate", gate, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_gate", gate, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_keep_total", res_total, 500);
        cnt = 0;
        for (int i = 0; i < S + 100; i++) begin
            tick();
            if (res_valid || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // abort wins over a same-cycle start
        start = 1'b1; abort = 1'b1; gate_len = 32'd100; tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_gate", gate, 0);

        run_meas(32'd100, 100, 32'd10, 32'd110, 32'd60, 32'd50, 0);
        finish_meas(0);
        run_meas(32'd40, 40, 32'd0, 32'd3000, 32'd1000, 32'd2000, 1);
        finish_meas(100);

        // clamping
        run_meas(32'd0, 16, 32'd0, 32'd9, 32'd4, 32'd5, 0);
        finish_meas(0);
        run_meas(32'd15, 16, 32'd0, 32'd9, 32'd4, 32'd5, 0);
        finish_meas(0);
        run_meas(32'd17, 17, 32'd0, 32'd9, 32'd4, 32'd5, 0);
        finish_meas(0);

        // maximum length: gate must still be open well after start
        gate_len = 32'hFFFF_FFFF; start = 1'b1; tick(); start = 1'b0;
        repeat (300) tick();
        check("max_len_gate", gate, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("max_len_abort", gate, 0);

        // async reset mid-GATE
        gate_len = 32'd100; start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0; #1;
        check("rst_gate_gate", gate, 0);
        check("rst_gate_busy", busy, 0);
        tick(); rst_n = 1'b1; tick();

        // async reset mid-SETTLE with a non-zero result latched
        run_meas(32'd16, 16, 32'd0, 32'd77, 32'd40, 32'd37, 0);
        finish_meas(0);
        gate_len = 32'd16; start = 1'b1; tick(); start = 1'b0;
        repeat (16 + 10) tick();
        check("settle_gate", gate, 0);
        check("settle_busy", busy, 1);
        rst_n = 1'b0; #1;
        check("rst_settle_busy", busy, 0);
        check("rst_settle_gate", gate, 0);
        check("rst_settle_valid", res_valid, 0);
        check("rst_settle_total", res_total, 0);
        check("rst_settle_high", res_high, 0);
        check("rst_settle_low", res_low, 0);
        check("rst_settle_err", res_err, 0);
        tick(); rst_n = 1'b1; tick();

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
